// File: rtl/serdes_tx_scheduler_pkg.sv
// Shared types and header layout for the serial transmit scheduler.
// Frame header: source in bit 7, reserved 6:4, length-minus-one in 3:0.
package serdes_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    S_SYNC,
    S_IDLE,
    S_HDR,
    S_DATA,
    S_GAP
  } sched_state_t;

  localparam int HDR_SRC_BIT     = 7;
  localparam int HDR_RSV_MSB     = 6;
  localparam int HDR_RSV_LSB     = 4;
  localparam int HDR_LEN_MSB     = 3;
  localparam int HDR_LEN_LSB     = 0;
  localparam int MAX_FRAME_BYTES = 16;
  localparam int BCNT_W          = $clog2(MAX_FRAME_BYTES);

  function automatic logic [7:0] mk_hdr(
    input logic              src,
    input logic [BCNT_W-1:0] l
  );
    mk_hdr = '0;
    mk_hdr[HDR_SRC_BIT] = src;
    mk_hdr[HDR_RSV_MSB:HDR_RSV_LSB] = '0;
    mk_hdr[HDR_LEN_MSB:HDR_LEN_LSB] = l;
  endfunction

endpackage

// File: rtl/serdes_tx_scheduler_symbol_timer.sv
// Free-running mod-SYMBOL_CYCLES counter.
// Flags the last cycle of every symbol period.
module serdes_tx_scheduler_symbol_timer #(
  parameter int SYMBOL_CYCLES = 10
) (
  input  logic Clk,
  input  logic reset,
  output logic sym_tick
);

  localparam int W = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(SYMBOL_CYCLES - 1);

  logic [W-1:0] r_cnt;

  // count 0..SYMBOL_CYCLES-1 and wrap
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign sym_tick = (r_cnt == LAST);

endmodule

// File: rtl/serdes_tx_scheduler.sv
// Frame scheduler and round-robin arbiter for a shared 8b10b transmitter.
// Emits sync commas, header+data frames and inter-frame comma gaps.
module serdes_tx_scheduler
  import serdes_tx_scheduler_pkg::*;
#(
  parameter int SYMBOL_CYCLES = 10,
  parameter int SYNC_SYMBOLS  = 4,
  parameter int GAP_SYMBOLS   = 2
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [7:0]  len,
  input  logic [15:0] data,
  output logic [1:0]  pop,
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output logic [7:0]  Pin,
  output logic        send,
  output logic        sym_tick,
  input  logic        tx_err,
  output logic        err_sticky
);

  localparam logic [7:0] SYNC_LAST = 8'(SYNC_SYMBOLS - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_SYMBOLS - 1);

  sched_state_t      r_state, w_state;
  logic [7:0]        r_cnt, w_cnt;
  logic [BCNT_W-1:0] r_bcnt, w_bcnt;
  logic [BCNT_W-1:0] r_len, w_len;
  logic              r_src, w_src;
  logic              r_last, w_last;
  logic [7:0]        r_pin, w_pin;
  logic              r_send, w_send;
  logic [1:0]        r_grant, w_grant;
  logic              r_err;
  logic [1:0]        w_pop, w_done;
  logic              w_tick;
  logic              w_win;
  logic [BCNT_W-1:0] w_wlen;
  logic [7:0]        w_cur;
  logic [1:0]        w_src_oh;

  serdes_tx_scheduler_symbol_timer #(
    .SYMBOL_CYCLES(SYMBOL_CYCLES)
  ) u_timer (
    .Clk     (Clk),
    .reset   (reset),
    .sym_tick(w_tick)
  );

  // next state, link outputs and consume/done strobes, acting only on ticks
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_bcnt   = r_bcnt;
    w_len    = r_len;
    w_src    = r_src;
    w_last   = r_last;
    w_pin    = r_pin;
    w_send   = r_send;
    w_grant  = r_grant;
    w_pop    = '0;
    w_done   = '0;
    w_win    = (req == 2'b11) ? ~r_last : req[1];
    w_wlen   = w_win ? len[7:4] : len[3:0];
    w_cur    = r_src ? data[15:8] : data[7:0];
    w_src_oh = r_src ? 2'b10 : 2'b01;
    if (w_tick) begin
      unique case (r_state)
        S_SYNC: begin
          if (r_cnt == SYNC_LAST) begin
            w_state = S_IDLE;
            w_cnt   = '0;
          end else begin
            w_cnt = r_cnt + 8'd1;
          end
        end
        S_IDLE: begin
          w_pin  = '0;
          w_send = 1'b0;
          if (req != 2'b00) begin
            w_src   = w_win;
            w_len   = w_wlen;
            w_pin   = mk_hdr(w_win, w_wlen);
            w_send  = 1'b1;
            w_grant = w_win ? 2'b10 : 2'b01;
            w_state = S_HDR;
          end
        end
        S_HDR: begin
          w_pin   = w_cur;
          w_pop   = w_src_oh;
          w_bcnt  = '0;
          w_state = S_DATA;
        end
        S_DATA: begin
          if (r_bcnt == r_len) begin
            w_pin   = '0;
            w_send  = 1'b0;
            w_grant = '0;
            w_done  = w_src_oh;
            w_last  = r_src;
            w_cnt   = '0;
            w_state = S_GAP;
          end else begin
            w_pin  = w_cur;
            w_pop  = w_src_oh;
            w_bcnt = r_bcnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            w_state = S_IDLE;
            w_cnt   = '0;
          end else begin
            w_cnt = r_cnt + 8'd1;
          end
        end
        default: w_state = S_SYNC;
      endcase
    end
  end

  // state and registered link outputs
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state <= S_SYNC;
      r_cnt   <= '0;
      r_bcnt  <= '0;
      r_len   <= '0;
      r_src   <= 1'b0;
      r_last  <= 1'b1;
      r_pin   <= '0;
      r_send  <= 1'b0;
      r_grant <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bcnt  <= w_bcnt;
      r_len   <= w_len;
      r_src   <= w_src;
      r_last  <= w_last;
      r_pin   <= w_pin;
      r_send  <= w_send;
      r_grant <= w_grant;
    end
  end

  // encoder errors only matter while real data is on the wire
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (tx_err && r_send) begin
      r_err <= 1'b1;
    end
  end

  assign pop        = w_pop & {2{~reset}};
  assign done       = w_done & {2{~reset}};
  assign grant      = r_grant;
  assign Pin        = r_pin;
  assign send       = r_send;
  assign sym_tick   = w_tick;
  assign err_sticky = r_err;

endmodule

// File: tb/tb_serdes_tx_scheduler.sv
// Scoreboard bench for serdes_tx_scheduler: stimulus pushes expected
// symbols, a monitor pops and compares at each symbol start.
module tb_serdes_tx_scheduler;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = '0;
  logic [7:0]  len = '0;
  logic [15:0] data;
  logic [1:0]  pop, grant, done;
  logic [7:0]  Pin;
  logic        send, sym_tick, err_sticky;
  logic        tx_err = 1'b0;

  always #5 Clk = ~Clk;

  serdes_tx_scheduler #(
    .SYMBOL_CYCLES(10),
    .SYNC_SYMBOLS (4),
    .GAP_SYMBOLS  (2)
  ) dut (
    .Clk       (Clk),
    .reset     (reset),
    .req       (req),
    .len       (len),
    .data      (data),
    .pop       (pop),
    .grant     (grant),
    .done      (done),
    .Pin       (Pin),
    .send      (send),
    .sym_tick  (sym_tick),
    .tx_err    (tx_err),
    .err_sticky(err_sticky)
  );

  typedef struct {
    logic [7:0] pin;
    logic       src;
  } sym_t;

  sym_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  logic [7:0] mem0[16];
  logic [7:0] mem1[16];
  int idx0 = 0;
  int idx1 = 0;
  logic [1:0] adv = '0;
  int pops[2] = '{0, 0};
  int dones[2] = '{0, 0};
  int exp_len[2] = '{0, 0};

  assign data = {mem1[idx1[3:0]], mem0[idx0[3:0]]};

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input logic [7:0] pin, input logic src);
    sym_t e;
    e.pin = pin;
    e.src = src;
    exp_q.push_back(e);
  endtask

  // monitor: compare each new symbol, count pops/dones, frame length
  logic tick_d = 1'b0;
  logic send_d = 1'b0;
  int   gap = 1;
  int   min_gap = 4;
  int   fsym = 0;
  always @(negedge Clk) begin : mon
    sym_t e;
    if (reset) begin
      tick_d = 1'b0;
      send_d = 1'b0;
      gap = 1;
      min_gap = 4;
      fsym = 0;
    end else begin
      if (tick_d) begin
        if (send) begin
          if (!send_d) begin
            chk("comma_gap", {31'b0, gap >= min_gap}, 1);
            min_gap = 2;
            fsym = 0;
            gap = 0;
          end
          fsym++;
          if (exp_q.size() == 0) begin
            chk("send_unexpected", {31'b0, send}, 0);
          end else begin
            e = exp_q.pop_front();
            chk("pin", {24'b0, Pin}, {24'b0, e.pin});
            chk("grant", {30'b0, grant}, e.src ? 2 : 1);
          end
        end else begin
          gap++;
          chk("comma_pin_grant", {22'b0, Pin, grant}, 0);
        end
        send_d = send;
      end
      for (int i = 0; i < 2; i++) begin
        if (pop[i]) begin
          pops[i]++;
          adv[i] = 1'b1;
        end
        if (done[i]) begin
          dones[i]++;
          chk($sformatf("frame_syms%0d", i), fsym, exp_len[i] + 2);
        end
      end
      tick_d = sym_tick;
    end
  end

  // requester byte sources step to the next byte after a pop
  always @(posedge Clk) begin
    #1;
    if (adv[0]) idx0++;
    if (adv[1]) idx1++;
    adv = '0;
  end

  task automatic wait_done(input int i, input int budget);
    int n = 0;
    while (!done[i] && n < budget) begin
      @(negedge Clk);
      n++;
    end
    chk($sformatf("done%0d_seen", i), {31'b0, done[i]}, 1);
  endtask

  task automatic wait_pop0(input int budget);
    int n = 0;
    @(negedge Clk);
    while (!pop[0] && n < budget) begin
      @(negedge Clk);
      n++;
    end
    chk("pop0_seen", {31'b0, pop[0]}, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge Clk);
    reset = 1'b0;
  endtask

  initial begin : stim
    int t0, t1, n, p0, p1, d0;
    repeat (3) @(negedge Clk);
    chk("reset_outs", {15'b0, send, Pin, grant, pop, done, err_sticky,
        sym_tick}, 0);
    reset = 1'b0;

    n = 0;
    while (!sym_tick && n < 30) begin @(negedge Clk); n++; end
    t0 = n;
    @(negedge Clk); n++;
    while (!sym_tick && n < 60) begin @(negedge Clk); n++; end
    t1 = n;
    chk("tick_period", t1 - t0, 10);

    repeat (60) @(negedge Clk);
    chk("idle_pops", pops[0] + pops[1], 0);
    chk("idle_dones", dones[0] + dones[1], 0);

    // single frame, 3 bytes
    mem0[0] = 8'hAA; mem0[1] = 8'hBB; mem0[2] = 8'hCC;
    idx0 = 0;
    len = 8'h02;
    exp_len[0] = 2;
    push(8'h02, 0); push(8'hAA, 0); push(8'hBB, 0); push(8'hCC, 0);
    p0 = pops[0];
    req = 2'b01;
    wait_done(0, 300);
    req = 2'b00;
    repeat (40) @(negedge Clk);
    chk("t2_pops", pops[0] - p0, 3);
    chk("t2_dones", dones[0], 1);
    chk("t2_q_empty", exp_q.size(), 0);
    chk("t2_send_off", {31'b0, send}, 0);

    // both requesting after reset: requester 0 first
    do_reset();
    mem0[0] = 8'h11; mem1[0] = 8'h22; mem1[1] = 8'h33;
    idx0 = 0; idx1 = 0;
    len = 8'h10;
    exp_len[0] = 0; exp_len[1] = 1;
    push(8'h00, 0); push(8'h11, 0);
    push(8'h81, 1); push(8'h22, 1); push(8'h33, 1);
    p0 = pops[0]; p1 = pops[1];
    req = 2'b11;
    wait_done(0, 300);
    req[0] = 1'b0;
    wait_done(1, 300);
    req[1] = 1'b0;
    repeat (20) @(negedge Clk);
    chk("t3_pops0", pops[0] - p0, 1);
    chk("t3_pops1", pops[1] - p1, 2);
    chk("t3_q_empty", exp_q.size(), 0);

    // maximum length frame
    for (int i = 0; i < 16; i++) mem0[i] = 8'(i);
    idx0 = 0;
    len = 8'h0F;
    exp_len[0] = 15;
    push(8'h0F, 0);
    for (int i = 0; i < 16; i++) push(8'(i), 0);
    p0 = pops[0];
    req = 2'b01;
    wait_done(0, 400);
    req = 2'b00;
    repeat (20) @(negedge Clk);
    chk("t4_pops", pops[0] - p0, 16);
    chk("t4_q_empty", exp_q.size(), 0);

    // encoder error: ignored on commas, sticky during data
    chk("err_clear", {31'b0, err_sticky}, 0);
    tx_err = 1'b1;
    @(negedge Clk);
    tx_err = 1'b0;
    @(negedge Clk);
    chk("err_idle", {31'b0, err_sticky}, 0);
    mem0[0] = 8'h5A; mem0[1] = 8'h5B; mem0[2] = 8'h5C; mem0[3] = 8'h5D;
    idx0 = 0;
    len = 8'h03;
    exp_len[0] = 3;
    push(8'h03, 0); push(8'h5A, 0); push(8'h5B, 0);
    push(8'h5C, 0); push(8'h5D, 0);
    req = 2'b01;
    wait_pop0(300);
    repeat (3) @(negedge Clk);
    tx_err = 1'b1;
    @(negedge Clk);
    tx_err = 1'b0;
    chk("err_data", {31'b0, err_sticky}, 1);
    d0 = dones[0];
    wait_done(0, 300);
    req = 2'b00;
    repeat (20) @(negedge Clk);
    chk("t5_q_empty", exp_q.size(), 0);
    chk("err_held", {31'b0, err_sticky}, 1);

    // reset during the second data symbol
    mem0[0] = 8'h61; mem0[1] = 8'h62; mem0[2] = 8'h63; mem0[3] = 8'h64;
    idx0 = 0;
    push(8'h03, 0); push(8'h61, 0); push(8'h62, 0);
    push(8'h63, 0); push(8'h64, 0);
    req = 2'b01;
    wait_pop0(300);
    wait_pop0(30);
    @(negedge Clk);
    d0 = dones[0];
    reset = 1'b1;
    @(negedge Clk);
    chk("rst_mid_outs", {15'b0, send, grant, Pin, done, err_sticky}, 0);
    @(negedge Clk);
    exp_q.delete();
    idx0 = 0;
    push(8'h03, 0); push(8'h61, 0); push(8'h62, 0);
    push(8'h63, 0); push(8'h64, 0);
    reset = 1'b0;
    chk("rst_no_done", dones[0] - d0, 0);
    repeat (40) @(negedge Clk);
    chk("sync_no_send", {31'b0, send}, 0);
    wait_done(0, 300);
    req = 2'b00;
    repeat (20) @(negedge Clk);
    chk("t6_dones", dones[0] - d0, 1);
    chk("t6_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
